// File: rtl/mem_addr_seq_pkg.sv
// Shared types and constants for the memory address sequencer.
package mem_addr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DWELL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;
    localparam int         AVM_DATA_W      = 32;

endpackage

// File: rtl/mem_addr_seq_if.sv
// Avalon-MM bus between the sequencer (master) and a PIO slave (data register at offset 0).
interface mem_addr_seq_if;
    import mem_addr_seq_pkg::*;

    logic [1:0]            avm_address;
    logic                  avm_chipselect;
    logic                  avm_write_n;
    logic [AVM_DATA_W-1:0] avm_writedata;
    logic [AVM_DATA_W-1:0] avm_readdata;

    // No wait states: a cycle with chipselect=1 completes in that cycle, and
    // readdata is valid in the same cycle as a read (chipselect=1, write_n=1).
    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/mem_addr_seq_dwell.sv
// Dwell down-counter: load a value, decrement on request, flag when zero.
module mem_addr_seq_dwell #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_addr_sequencer.sv
// Steps an address from start_addr to end_addr, writing each to a PIO over Avalon-MM.
// Define MEM_ADDR_SEQ_READBACK_EN to read each write back and flag mismatches on err.
module mem_addr_sequencer
    import mem_addr_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  end_addr,
    input  logic [ADDR_W-1:0]  stride,
    input  logic [DWELL_W-1:0] dwell,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  cur_addr,
    output logic               err,
    mem_addr_seq_if.master     avm,
    output state_t             state_dbg
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, end_q, stride_q;
    logic [DWELL_W-1:0] dwell_q, dwell_ld_val;
    logic               dwell_load, dwell_dec, dwell_zero;
    logic [ADDR_W:0]    next_addr;
    logic               last_addr;
    logic [AVM_DATA_W-1:0] addr_word;

    // One extra bit so an overflowing step is seen as "past the end", never a wrap.
    assign next_addr = {1'b0, cur_addr_q} + {1'b0, stride_q};
    assign last_addr = (cur_addr_q >= end_q) || (next_addr > {1'b0, end_q});
    assign addr_word = {{(AVM_DATA_W-ADDR_W){1'b0}}, cur_addr_q};

    // The decision cycle counts as the first dwell cycle, so load dwell-1.
    assign dwell_ld_val = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

    mem_addr_seq_dwell #(.DWELL_W(DWELL_W)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (dwell_load),
        .load_val (dwell_ld_val),
        .dec      (dwell_dec),
        .zero     (dwell_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        dwell_load         = 1'b0;
        dwell_dec          = 1'b0;
        avm.avm_address    = PIO_DATA_OFFSET;
        avm.avm_chipselect = 1'b0;
        avm.avm_write_n    = 1'b1;
        avm.avm_writedata  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WRITE;
            end
            S_WRITE: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_writedata  = addr_word;
                dwell_load         = 1'b1;
`ifdef MEM_ADDR_SEQ_READBACK_EN
                state_d = S_READ;
`else
                state_d = S_DWELL;
`endif
            end
            S_READ: begin
                avm.avm_chipselect = 1'b1;
                dwell_load         = 1'b1;
                state_d            = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_zero) begin
                    state_d = last_addr ? S_DONE : S_WRITE;
                end else begin
                    dwell_dec = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr_q <= '0;
            end_q      <= '0;
            stride_q   <= '0;
            dwell_q    <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            cur_addr_q <= start_addr;
            end_q      <= end_addr;
            stride_q   <= (stride == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1} : stride;
            dwell_q    <= dwell;
        end else if ((state_q == S_DWELL) && dwell_zero && !last_addr) begin
            cur_addr_q <= next_addr[ADDR_W-1:0];
        end
    end

`ifdef MEM_ADDR_SEQ_READBACK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            err_q <= 1'b0;
        end else if ((state_q == S_READ) && (avm.avm_readdata != addr_word)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^avm.avm_readdata;
    assign err = 1'b0;
`endif

    assign busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DWELL);
    assign done      = (state_q == S_DONE);
    assign cur_addr  = cur_addr_q;
    assign state_dbg = state_q;

endmodule

// File: doc/mem_addr_sequencer.md
MEM_ADDR_SEQUENCER -- requirements
Module: mem_addr_sequencer

Interface
- REQ-001 SHALL have parameter ADDR_W, default 8, sequenced address width (equals PIO out_port width).
- REQ-002 SHALL have parameter DWELL_W, default 16, dwell counter width.
- REQ-003 SHALL have port clk, input, 1, sole clock; all state rising-edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port start, input, 1, single-cycle run request; ignored while busy=1.
- REQ-006 SHALL have ports start_addr, end_addr, stride, inputs, ADDR_W each, run bounds and step; latched on accepted start.
- REQ-007 SHALL have port dwell, input, DWELL_W, idle cycles held per address; latched on accepted start.
- REQ-008 SHALL have ports busy (1), done (1), cur_addr (ADDR_W), err (1), outputs: run active, end-of-run pulse, last written address, sticky readback mismatch.
- REQ-009 SHALL have Avalon-MM master outputs avm_address (2), avm_chipselect (1), avm_write_n (1), avm_writedata (32), and input avm_readdata (32), targeting a PIO slave whose data register sits at offset 0.

Function
- REQ-010 SHALL implement FSM IDLE, WRITE, READ, DWELL, DONE; READ exists only per REQ-024.
- REQ-011 SHALL, in IDLE with start=1, latch inputs, set cur_addr=start_addr, enter WRITE; busy=1 from next cycle.
- REQ-012 SHALL, in WRITE, drive for exactly one cycle avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata={zeros, cur_addr}.
- REQ-013 SHALL, outside WRITE/READ, drive avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
- REQ-014 SHALL, in DWELL, count dwell cycles; dwell=0 leaves DWELL after one cycle (decision cycle only).
- REQ-015 SHALL, on DWELL exit, compute next=cur_addr+stride in ADDR_W+1 bits; stride=0 treated as 1.
- REQ-016 SHALL go to DONE if cur_addr>=end_addr or next>end_addr (no wrap-around); else cur_addr<=next[ADDR_W-1:0] and WRITE.
- REQ-017 SHALL, when start_addr>end_addr, perform exactly one write of start_addr then DONE.
- REQ-018 SHALL, in DONE, assert done for exactly one cycle, deassert busy, return to IDLE; start in DONE is ignored.
- REQ-019 SHALL hold cur_addr after a run until the next accepted start.
- REQ-020 SHALL take per address: 1 (WRITE) + 1 (READ if enabled) + max(dwell,1) cycles.

Reset
- REQ-021 SHALL, on reset=1 at any time including mid-run, go to IDLE with busy=0, done=0, err=0, cur_addr=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
- REQ-022 SHALL abort an in-flight bus cycle on reset; no completion or done pulse follows.
- REQ-023 SHALL clear err only by reset or accepted start.

Configuration
- REQ-024 SHALL, with MEM_ADDR_SEQ_READBACK_EN defined, insert READ after each WRITE: avm_chipselect=1, avm_write_n=1, avm_address=0; sample avm_readdata same cycle; set err if readdata != {zeros, cur_addr}.
- REQ-025 SHALL, without MEM_ADDR_SEQ_READBACK_EN, omit READ, ignore avm_readdata, and tie err=0.

Structure
- REQ-026 SHALL place FSM state enum, PIO data offset constant (0) and avm data width (32) in shared package mem_addr_seq_pkg.
- REQ-027 SHALL place dwell counter in sub-module mem_addr_seq_dwell (load, decrement, zero flag).

Verification
- REQ-028 SHALL cover start_addr=0x10, end_addr=0x13, stride=1, dwell=2 -> writes 0x10,0x11,0x12,0x13, 3 cycles apart (no readback); one done pulse; cur_addr=0x13.
- REQ-029 SHALL cover start_addr=0xF0, end_addr=0xFF, stride=0x08 -> writes 0xF0,0xF8 only; no wrap to 0x00.
- REQ-030 SHALL cover stride=0, start 0x05, end 0x07 -> writes 0x05,0x06,0x07; start_addr=0x20, end_addr=0x10 -> single write 0x20, done.
- REQ-031 SHALL cover readback build with PIO model forcing bit 0 of readdata high on 0x02 -> err=1 after that READ, run still completes, err stays 1 until next start.
- REQ-032 SHALL cover reset asserted during WRITE of 0x11 -> same-cycle async return to reset values; no done; new start runs normally.
- REQ-033 SHALL cover start pulsed while busy=1 -> ignored; write sequence unchanged.
